if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface.
- Owns the fetch PC, drives the word-aligned byte address into the combinational instruction memory, and captures the returned word.
- Buffers fetched {pc, instr} pairs in a small FIFO and presents them to decode over a valid/ready handshake.
- Handles control-flow redirects (branch/jump) by flushing the buffer and reloading the PC.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset; bits [1:0] must be zero.
- DEPTH, 2, FIFO entries (power of two, 2..8).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- fetch_en  input  1  permits new fetches when high
- imem_addr  output  32  byte address to instruction memory; always a multiple of 4
- imem_rdata  input  32  instruction word, valid in the same cycle as imem_addr (combinational memory)
- redirect_valid  input  1  one-cycle request to change the fetch stream
- redirect_pc  input  32  new fetch address
- out_valid  output  1  FIFO head valid toward decode
- out_ready  input  1  decode accepts head
- out_pc  output  32  PC of the head entry
- out_instr  output  32  instruction of the head entry
- misalign_err  output  1  one-cycle pulse when a redirect target has bits [1:0] != 0
- fetch_count  output  32  count of completed out handshakes; wraps at 2^32

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - fetch_pc = RESET_PC, FIFO empty, out_valid = 0.
  - out_pc = 0, out_instr = 0 (head registers cleared).
  - misalign_err = 0, fetch_count = 0.
- imem_addr = fetch_pc, combinational from register.
- pop = out_valid & out_ready.
- push = fetch_en & ~redirect_valid & (count < DEPTH | pop).
  - A full FIFO with a simultaneous pop still pushes.
  - On push: write {fetch_pc, imem_rdata} at the tail; fetch_pc <= fetch_pc + 4 (32-bit wrap, 0xFFFF_FFFC -> 0x0).
- Latency: a word fetched in cycle N is visible on out_* in cycle N+1 if the FIFO was empty.
  - First out_valid appears 1 cycle after the first clock edge with rst_n high and fetch_en high.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither. out_valid = (count != 0).
- Redirect has priority over push:
  - In the cycle redirect_valid = 1, FIFO flushes at the edge and fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - No push that cycle.
  - out_valid is 0 in the following cycle.
  - Fetch from the new PC begins that following cycle; its first instr is valid one cycle later.
- Redirect with a simultaneous pop: the handshake counts as completed; fetch_count increments; the entry is consumed, not replayed.
- misalign_err pulses high for exactly the cycle after a redirect whose redirect_pc[1:0] != 0. The PC is still force-aligned.
- fetch_en low: no pushes; fetch_pc holds; FIFO continues to drain; redirects are still accepted.
- Stalled decode (out_ready low, FIFO full): fetch_pc holds; imem_addr stable; out_pc and out_instr stable while out_valid is high.
- Reset mid-stream: all state returns to reset values immediately; no partial entry survives.
- out_pc and out_instr are held at their last value when the FIFO is empty. They are don't-care for checking while out_valid = 0.

Test Plan:
- Straight-line fetch:
  - Stimulus: memory[0] = 0x00500113, memory[4] = 0x00C00193, memory[8] = 0xFF718393; fetch_en = 1, out_ready = 1 after reset.
  - Required: out_pc sequence 0, 4, 8 with those words on consecutive cycles starting 1 cycle after reset release; fetch_count = 3 after 3 handshakes.
- Backpressure with DEPTH = 2:
  - Stimulus: out_ready = 0 for 5 cycles.
  - Required: exactly 2 entries held (pc 0, pc 4); imem_addr frozen at 8; on out_ready = 1, pcs 0, 4, 8 are delivered in order with no loss or duplicate.
- Redirect:
  - Stimulus: redirect_valid with redirect_pc = 0x40 while entries pc 8 and pc 12 are buffered.
  - Required: out_valid = 0 the next cycle; next delivered out_pc = 0x40 with memory[0x40]; pcs 8 and 12 never appear.
- Misaligned redirect:
  - Stimulus: redirect_pc = 0x26.
  - Required: misalign_err high for 1 cycle; next out_pc = 0x24.
- Redirect with simultaneous pop, and full push/pop:
  - Stimulus (a): redirect and pop in the same cycle.
  - Required (a): fetch_count increments by 1 and the popped entry is not re-presented.
  - Stimulus (b): FIFO full plus pop.
  - Required (b): push still occurs and count stays 2.
- Async reset mid-stream:
  - Stimulus: assert rst_n = 0 between clock edges with 2 entries buffered.
  - Required: out_valid = 0 and imem_addr = RESET_PC immediately; after release, fetch restarts at RESET_PC and fetch_count = 0.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, reads a combinational instruction
// memory and buffers {pc, instr} pairs toward decode over valid/ready.

package if_fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  // One buffered fetch result
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[XLEN-1:2], 2'b00};
  localparam logic [XLEN-1:0] PC_STEP          = XLEN'(4);

  // Buffer storage, pointers and occupancy
  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Fetch PC and registered outputs
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  fetch_entry_t     head_q, head_d;
  logic             out_valid_q, out_valid_d;
  logic             misalign_q, misalign_d;
  logic [XLEN-1:0]  fetch_count_q, fetch_count_d;

  // Per-cycle handshake decisions
  logic             pop_c;
  logic             push_c;
  logic             room_c;
  logic [CNT_W-1:0] remain_c;
  fetch_entry_t     new_entry_c;

  // Next-state logic: redirect flushes and reloads the PC, otherwise push/pop
  always_comb begin
    pop_c         = out_valid_q & out_ready;
    room_c        = (count_q < CNT_W'(DEPTH)) | pop_c;
    push_c        = fetch_en & ~redirect_valid & room_c;
    new_entry_c   = '{pc: fetch_pc_q, instr: imem_rdata};
    remain_c      = count_q - CNT_W'(pop_c);

    fetch_pc_d    = fetch_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    head_d        = head_q;
    fetch_count_d = fetch_count_q + XLEN'(pop_c);
    misalign_d    = redirect_valid & (|redirect_pc[1:0]);

    if (redirect_valid) begin
      // A pop in this cycle still completes; everything else is discarded
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push_c) begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

      // The head comes from the incoming word when nothing older remains
      if (remain_c == '0) begin
        if (push_c) begin
          head_d = new_entry_c;
        end
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end

    out_valid_d = (count_d != '0);
  end

  // Buffer storage write; occupancy tracking makes stale contents invisible
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= new_entry_c;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC_ALIGNED;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      head_q        <= '0;
      out_valid_q   <= 1'b0;
      misalign_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      head_q        <= head_d;
      out_valid_q   <= out_valid_d;
      misalign_q    <= misalign_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr    = fetch_pc_q;
  assign out_valid    = out_valid_q;
  assign out_pc       = head_q.pc;
  assign out_instr    = head_q.instr;
  assign misalign_err = misalign_q;
  assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: directed scenarios plus randomized traffic
// checked against a queue-based reference model.

module tb_if_fetch_unit;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int n_cmp;
  int n_bad;

  // Reference model state
  logic [31:0] mq_pc [$];
  logic [31:0] mq_in [$];
  logic [31:0] m_pc;
  logic [31:0] m_fc;
  logic        m_mis;

  if_fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .misalign_err   (misalign_err),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0113;
      32'h4:   return 32'h00C0_0193;
      32'h8:   return 32'hFF71_8393;
      default: return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endcase
  endfunction

  assign imem_rdata = mem_fn(imem_addr);

  task automatic model_reset();
    mq_pc.delete();
    mq_in.delete();
    m_pc  = RST_PC;
    m_fc  = 0;
    m_mis = 1'b0;
  endtask

  // Advance one clock: called at a negedge with inputs set, returns at next negedge
  task automatic step();
    logic pop, push;
    pop  = (mq_pc.size() != 0) && out_ready;
    push = fetch_en && !redirect_valid && ((mq_pc.size() < DEPTH) || pop);
    @(posedge clk);
    if (pop) begin
      void'(mq_pc.pop_front());
      void'(mq_in.pop_front());
      m_fc = m_fc + 1;
    end
    m_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
    if (redirect_valid) begin
      mq_pc.delete();
      mq_in.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
    end else if (push) begin
      mq_pc.push_back(m_pc);
      mq_in.push_back(mem_fn(m_pc));
      m_pc = m_pc + 32'd4;
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    fetch_en = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    model_reset();
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_cmp++; if (imem_addr !== RST_PC) begin n_bad++; $display("FAIL reset_imem_addr got %h exp %h", imem_addr, RST_PC); end
    n_cmp++; if (out_pc !== 32'h0) begin n_bad++; $display("FAIL reset_out_pc got %h exp 0", out_pc); end
    n_cmp++; if (out_instr !== 32'h0) begin n_bad++; $display("FAIL reset_out_instr got %h exp 0", out_instr); end
    n_cmp++; if (misalign_err !== 1'b0) begin n_bad++; $display("FAIL reset_misalign got %b exp 0", misalign_err); end
    n_cmp++; if (fetch_count !== 32'h0) begin n_bad++; $display("FAIL reset_fetch_count got %0d exp 0", fetch_count); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_straight_line();
    logic [31:0] exp_pc [3];
    logic [31:0] exp_in [3];
    exp_pc = '{32'h0, 32'h4, 32'h8};
    exp_in = '{32'h0050_0113, 32'h00C0_0193, 32'hFF71_8393};
    fetch_en = 1'b1;
    out_ready = 1'b1;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL straight_valid[%0d] got %b exp 1", i, out_valid); end
      n_cmp++; if (out_pc !== exp_pc[i]) begin n_bad++; $display("FAIL straight_pc[%0d] got %h exp %h", i, out_pc, exp_pc[i]); end
      n_cmp++; if (out_instr !== exp_in[i]) begin n_bad++; $display("FAIL straight_instr[%0d] got %h exp %h", i, out_instr, exp_in[i]); end
      n_cmp++; if (fetch_count !== 32'(i)) begin n_bad++; $display("FAIL straight_count[%0d] got %0d exp %0d", i, fetch_count, i); end
    end
    step();
    n_cmp++; if (fetch_count !== 32'd3) begin n_bad++; $display("FAIL straight_count_final got %0d exp 3", fetch_count); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc [3];
    exp_pc = '{32'h0, 32'h4, 32'h8};
    fetch_en = 1'b1;
    out_ready = 1'b0;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      if (i >= 1) begin
        n_cmp++; if (imem_addr !== 32'h8) begin n_bad++; $display("FAIL bp_addr_frozen[%0d] got %h exp 8", i, imem_addr); end
      end
      n_cmp++; if (out_pc !== 32'h0 || out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_head_stable[%0d] got pc %h v %b exp pc 0 v 1", i, out_pc, out_valid); end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (out_pc !== exp_pc[i] || out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_drain[%0d] got pc %h v %b exp pc %h", i, out_pc, out_valid, exp_pc[i]); end
      step();
    end
    n_cmp++; if (fetch_count !== 32'd3) begin n_bad++; $display("FAIL bp_count got %0d exp 3", fetch_count); end
  endtask

  task automatic test_redirect();
    fetch_en = 1'b1;
    out_ready = 1'b0;
    apply_reset();
    step();
    step();
    out_ready = 1'b1;
    step();
    step();
    n_cmp++; if (out_pc !== 32'h8 || imem_addr !== 32'h10) begin n_bad++; $display("FAIL redir_setup got pc %h addr %h exp pc 8 addr 10", out_pc, imem_addr); end
    out_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL redir_valid_low got %b exp 0", out_valid); end
    n_cmp++; if (imem_addr !== 32'h40) begin n_bad++; $display("FAIL redir_addr got %h exp 40", imem_addr); end
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h40) begin n_bad++; $display("FAIL redir_first got pc %h v %b exp pc 40", out_pc, out_valid); end
    n_cmp++; if (out_instr !== mem_fn(32'h40)) begin n_bad++; $display("FAIL redir_instr got %h exp %h", out_instr, mem_fn(32'h40)); end
    n_cmp++; if (fetch_count !== 32'd2) begin n_bad++; $display("FAIL redir_count got %0d exp 2", fetch_count); end
    step();
    n_cmp++; if (out_pc !== 32'h44) begin n_bad++; $display("FAIL redir_second got %h exp 44", out_pc); end
  endtask

  // Continues from test_redirect: head is 0x44 with out_ready high
  task automatic test_misalign_with_pop();
    logic [31:0] fc0;
    fc0 = fetch_count;
    redirect_valid = 1'b1;
    redirect_pc = 32'h26;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (misalign_err !== 1'b1) begin n_bad++; $display("FAIL mis_pulse got %b exp 1", misalign_err); end
    n_cmp++; if (fetch_count !== fc0 + 32'd1) begin n_bad++; $display("FAIL mis_pop_count got %0d exp %0d", fetch_count, fc0 + 32'd1); end
    n_cmp++; if (imem_addr !== 32'h24 || out_valid !== 1'b0) begin n_bad++; $display("FAIL mis_addr got %h v %b exp 24 v 0", imem_addr, out_valid); end
    step();
    n_cmp++; if (misalign_err !== 1'b0) begin n_bad++; $display("FAIL mis_one_cycle got %b exp 0", misalign_err); end
    n_cmp++; if (out_pc !== 32'h24 || out_valid !== 1'b1) begin n_bad++; $display("FAIL mis_next_pc got %h v %b exp 24", out_pc, out_valid); end
    step();
    n_cmp++; if (out_pc !== 32'h28) begin n_bad++; $display("FAIL mis_no_replay got %h exp 28", out_pc); end
  endtask

  task automatic test_full_push_pop();
    fetch_en = 1'b1;
    out_ready = 1'b0;
    apply_reset();
    step();
    step();
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_pc !== 32'h4 || imem_addr !== 32'hC) begin n_bad++; $display("FAIL full_pushpop got pc %h addr %h exp pc 4 addr c", out_pc, imem_addr); end
    out_ready = 1'b0;
    step();
    n_cmp++; if (imem_addr !== 32'hC || out_valid !== 1'b1) begin n_bad++; $display("FAIL full_still_full got addr %h v %b exp c", imem_addr, out_valid); end
  endtask

  task automatic test_async_reset();
    fetch_en = 1'b1;
    out_ready = 1'b0;
    apply_reset();
    step();
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++; if (fetch_count !== 32'd1) begin n_bad++; $display("FAIL areset_pre_count got %0d exp 1", fetch_count); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL areset_valid got %b exp 0", out_valid); end
    n_cmp++; if (imem_addr !== RST_PC) begin n_bad++; $display("FAIL areset_addr got %h exp %h", imem_addr, RST_PC); end
    n_cmp++; if (fetch_count !== 32'd0) begin n_bad++; $display("FAIL areset_count got %0d exp 0", fetch_count); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_pc !== RST_PC || out_instr !== mem_fn(RST_PC) || out_valid !== 1'b1) begin n_bad++; $display("FAIL areset_restart got pc %h instr %h", out_pc, out_instr); end
    n_cmp++; if (fetch_count !== 32'd0) begin n_bad++; $display("FAIL areset_restart_count got %0d exp 0", fetch_count); end
  endtask

  task automatic test_random();
    logic [1:0] sel;
    fetch_en = 1'b1;
    out_ready = 1'b1;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      fetch_en = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      sel = 2'($urandom_range(0, 3));
      case (sel)
        2'd0:    redirect_pc = $urandom;
        2'd1:    redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: redirect_pc = 32'($urandom_range(0, 255));
      endcase
      step();
      redirect_valid = 1'b0;
      n_cmp++; if (out_valid !== (mq_pc.size() != 0)) begin n_bad++; $display("FAIL rnd_valid[%0d] got %b exp %b", i, out_valid, mq_pc.size() != 0); end
      n_cmp++; if (imem_addr !== m_pc) begin n_bad++; $display("FAIL rnd_addr[%0d] got %h exp %h", i, imem_addr, m_pc); end
      n_cmp++; if (fetch_count !== m_fc) begin n_bad++; $display("FAIL rnd_count[%0d] got %0d exp %0d", i, fetch_count, m_fc); end
      n_cmp++; if (misalign_err !== m_mis) begin n_bad++; $display("FAIL rnd_misalign[%0d] got %b exp %b", i, misalign_err, m_mis); end
      if (mq_pc.size() != 0) begin
        n_cmp++; if (out_pc !== mq_pc[0] || out_instr !== mq_in[0]) begin n_bad++; $display("FAIL rnd_head[%0d] got %h/%h exp %h/%h", i, out_pc, out_instr, mq_pc[0], mq_in[0]); end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_straight_line();
    test_backpressure();
    test_redirect();
    test_misalign_with_pop();
    test_full_push_pop();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
